// File: rtl/mini_aie_host_link.sv
// mini_aie_host_link: host-side driver for the mini-AIE 2x2 tile pin protocol.
// Serializes 16-bit commands as four strobed nibbles on ui_in, and for START
// waits for the chip's result_valid pin and returns the result byte.
// Optional WAIT_RSP timeout: define MINI_AIE_HOST_TIMEOUT_EN.
module mini_aie_host_link #(
  parameter int unsigned STROBE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic [7:0]  ui_in_drv,
  input  logic [7:0]  uo_out_smp,
  input  logic [7:0]  uio_out_smp,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  // Phase counter must reach STROBE_CYCLES (the pins-to-zero tail of the last nibble).
  localparam int unsigned PH_W = $clog2(STROBE_CYCLES + 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SETUP    = 3'd1;
  localparam logic [2:0] STROBE   = 3'd2;
  localparam logic [2:0] WAIT_RSP = 3'd3;
  localparam logic [2:0] RSP      = 3'd4;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_START = 2'b11;

  // Reject parameter values outside the supported range at elaboration.
  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("mini_aie_host_link: illegal STROBE_CYCLES or TIMEOUT_CYCLES");
  end

  logic [2:0]      state, state_nxt;
  logic [1:0]      nib_idx, nib_nxt;
  logic [PH_W-1:0] phase, phase_nxt;
  logic [1:0]      op_q, op_nxt;
  logic [15:0]     data_q, data_nxt;
  logic [7:0]      rsp_data_nxt;
  logic            rsp_err_nxt;
  logic [7:0]      drive_c;
  logic [3:0]      nib_c;
  logic            last_nib;
  logic            sync1, sync2;
  logic            unused_uio;

`ifdef MINI_AIE_HOST_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
`endif

  assign cmd_ready  = (state == IDLE);
  assign unused_uio = ^uio_out_smp[7:1];

  // Next-state, datapath and pin-drive decode.
  always_comb begin
    state_nxt    = state;
    nib_nxt      = nib_idx;
    phase_nxt    = phase;
    op_nxt       = op_q;
    data_nxt     = data_q;
    rsp_data_nxt = rsp_data;
    rsp_err_nxt  = rsp_err;
    drive_c      = 8'h00;
    last_nib     = (nib_idx == 2'd3);
    nib_c        = 4'(data_q >> {nib_idx, 2'b00});
`ifdef MINI_AIE_HOST_TIMEOUT_EN
    to_cnt_nxt   = to_cnt;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          op_nxt   = cmd_op;
          data_nxt = cmd_data;
          if (cmd_op != OP_NOP) begin
            state_nxt = SETUP;
            nib_nxt   = 2'd0;
            phase_nxt = '0;
          end
        end
      end
      SETUP: begin
        drive_c   = {2'b00, op_q, nib_c};
        state_nxt = STROBE;
        phase_nxt = '0;
      end
      STROBE: begin
        // Last nibble holds one extra phase so the pins read zero before leaving.
        if (phase != PH_W'(STROBE_CYCLES)) drive_c = {2'b01, op_q, nib_c};
        if (!last_nib && phase == PH_W'(STROBE_CYCLES - 1)) begin
          state_nxt = SETUP;
          nib_nxt   = nib_idx + 2'd1;
          phase_nxt = '0;
        end else if (last_nib && phase == PH_W'(STROBE_CYCLES)) begin
          state_nxt = (op_q == OP_START) ? WAIT_RSP : IDLE;
`ifdef MINI_AIE_HOST_TIMEOUT_EN
          to_cnt_nxt = '0;
`endif
        end else begin
          phase_nxt = phase + PH_W'(1);
        end
      end
      WAIT_RSP: begin
        if (sync2) begin
          rsp_data_nxt = uo_out_smp;
          rsp_err_nxt  = 1'b0;
          state_nxt    = RSP;
        end
`ifdef MINI_AIE_HOST_TIMEOUT_EN
        else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_nxt = 8'hFF;
          rsp_err_nxt  = 1'b1;
          state_nxt    = RSP;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
`endif
      end
      RSP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath, synchronizer and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      nib_idx   <= 2'd0;
      phase     <= '0;
      op_q      <= 2'b00;
      data_q    <= 16'h0000;
      ui_in_drv <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
`ifdef MINI_AIE_HOST_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      state     <= state_nxt;
      nib_idx   <= nib_nxt;
      phase     <= phase_nxt;
      op_q      <= op_nxt;
      data_q    <= data_nxt;
      ui_in_drv <= drive_c;
      rsp_valid <= (state_nxt == RSP);
      rsp_data  <= rsp_data_nxt;
      rsp_err   <= rsp_err_nxt;
      busy      <= (state_nxt != IDLE);
      sync1     <= uio_out_smp[0];
      sync2     <= sync1;
`ifdef MINI_AIE_HOST_TIMEOUT_EN
      to_cnt    <= to_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mini_aie_host_link.sv
// tb_mini_aie_host_link: randomized bench for mini_aie_host_link with a
// command-level reference model of the pin trace and response timing.
module tb_mini_aie_host_link;

  localparam int unsigned S  = 2;
  localparam int unsigned TO = 16;
  localparam logic [1:0] NOP = 2'b00, CFG = 2'b01, DWR = 2'b10, START = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [7:0]  ui_in_drv;
  logic [7:0]  uo_out_smp;
  logic [7:0]  uio_out_smp;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mini_aie_host_link #(.STROBE_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .ui_in_drv(ui_in_drv), .uo_out_smp(uo_out_smp), .uio_out_smp(uio_out_smp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One command end to end. vdly: chip raises result_valid after edge 13+vdly
  // (edge 13 is where the pins return to zero). no_rsp: chip never answers.
  task automatic do_cmd(input logic [1:0] op, input logic [15:0] data, input int vdly,
                        input int hold, input logic [7:0] res, input bit no_rsp);
    logic [7:0] exp_ui [$];
    logic [7:0] exp_data;
    logic [3:0] nib;
    logic       exp_err;
    int         r_exp;
    int         last;
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_data  = 16'($urandom);
    if (op == NOP) begin
      check("nop_ui", ui_in_drv, 0);
      check("nop_ready", cmd_ready, 1);
      check("nop_busy", busy, 0);
      return;
    end
    check("acc_busy", busy, 1);
    check("acc_ready", cmd_ready, 0);
    check("acc_ui", ui_in_drv, 0);
    for (int k = 0; k < 4; k++) begin
      nib = 4'(data >> (4 * k));
      exp_ui.push_back({2'b00, op, nib});
      for (int s = 0; s < int'(S); s++) exp_ui.push_back({2'b01, op, nib});
    end
    exp_ui.push_back(8'h00);
    exp_data = no_rsp ? 8'hFF : res;
    exp_err  = no_rsp;
    if (no_rsp) r_exp = 13 + int'(TO);
    else        r_exp = (16 + vdly > 14) ? 16 + vdly : 14;
    last = (op == START) ? r_exp : 13;
    for (int t = 1; t <= last; t++) begin
      tick();
      cmd_valid = (t < 11) ? 1'($urandom) : 1'b0;
      cmd_op    = 2'($urandom);
      if (op == START && !no_rsp && t == 13 + vdly) begin
        uio_out_smp = 8'h01;
        uo_out_smp  = res;
      end
      if (t <= 13) check("ui_trace", ui_in_drv, exp_ui[t-1]);
      if (op != START) begin
        check("wr_ready", cmd_ready, (t == 13));
        check("wr_busy", busy, (t != 13));
      end else begin
        check("rsp_valid_timing", rsp_valid, (t == r_exp));
        check("start_busy", busy, 1);
        if (t == r_exp) begin
          check("rsp_data", rsp_data, exp_data);
          check("rsp_err", rsp_err, exp_err);
        end
      end
    end
    if (op != START) return;
    for (int h = 0; h < hold; h++) begin
      uo_out_smp  = 8'($urandom);
      uio_out_smp = 8'($urandom);
      tick();
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_data, exp_data);
      check("hold_err", rsp_err, exp_err);
      check("hold_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready   = 1'b0;
    uio_out_smp = 8'h00;
    check("consume_valid", rsp_valid, 0);
    check("consume_ready", cmd_ready, 1);
    check("consume_busy", busy, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    cmd_valid   = 1'b1;
    cmd_op      = CFG;
    cmd_data    = 16'hFFFF;
    uo_out_smp  = 8'h00;
    uio_out_smp = 8'h00;
    rsp_ready   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ui", ui_in_drv, 0);
      check("rst_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 0);
    end
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_ui", ui_in_drv, 0);

    do_cmd(CFG, 16'hA5C3, 0, 0, 8'h00, 1'b0);
    do_cmd(NOP, 16'h1234, 0, 0, 8'h00, 1'b0);
    do_cmd(DWR, 16'h0001, 0, 0, 8'h00, 1'b0);
    do_cmd(START, 16'h0000, 5, 4, 8'h3C, 1'b0);
    do_cmd(START, 16'hBEEF, -2, 1, 8'h81, 1'b0);

    // Reset during the strobe of the second nibble aborts the command.
    cmd_valid = 1'b1;
    cmd_op    = CFG;
    cmd_data  = 16'($urandom);
    tick();
    cmd_valid = 1'b0;
    repeat (5) tick();
    check("mid_strobe", ui_in_drv[6], 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_ui", ui_in_drv, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", cmd_ready, 1);
    do_cmd(CFG, 16'h9E17, 0, 0, 8'h00, 1'b0);

`ifdef MINI_AIE_HOST_TIMEOUT_EN
    do_cmd(START, 16'h4321, 0, 2, 8'h00, 1'b1);
`endif

    for (int i = 0; i < 40; i++) begin
      do_cmd(2'($urandom), 16'($urandom), int'($urandom_range(8)) - 2,
             int'($urandom_range(4)), 8'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/mini_aie_host_link.md
Name: mini_aie_host_link

Overview:
- Host-side driver for the mini-AIE 2x2 tile pin protocol. It is the initiator on the far end of the chip's ui_in/uo_out/uio_out pins.
- Takes 16-bit commands on a valid/ready interface and serializes each command as four strobed nibbles onto the chip's dedicated inputs.
- For START commands, it waits for the chip's result-valid pin, captures the result byte and returns it on a response valid/ready interface.
- Used in the FPGA bring-up harness and the RTL system bench in place of hand-driven pin stimulus.

Parameters:
- STROBE_CYCLES, 2, cycles strobe is held high per nibble (legal range 1..15).
- TIMEOUT_CYCLES, 1024, WAIT_RSP cycles before a timeout response (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, active low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  00 NOP, 01 CFG_WR, 10 DATA_WR, 11 START
- cmd_data  in  16  command payload
- ui_in_drv  out  8  drives chip ui_in: [3:0] nibble, [5:4] op, [6] strobe, [7] 0
- uo_out_smp  in  8  chip uo_out (result byte)
- uio_out_smp  in  8  chip uio_out; bit 0 = result_valid, other bits ignored
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_data  out  8  captured result byte
- rsp_err  out  1  response is a timeout (0 when the feature is off)
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset is synchronous and active-low on rst_n, single clock clk. While rst_n=0 at a rising edge, all regs clear:
  - state=IDLE
  - ui_in_drv=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0
  - synchronizer flops=0
- cmd_ready = (state==IDLE), combinational. A command is accepted on a cycle where cmd_valid & cmd_ready. cmd_op and cmd_data are latched at acceptance.
- States: IDLE, SETUP, STROBE, WAIT_RSP, RSP.
- NOP: accepted with no pin activity; stays in IDLE; cmd_ready remains high.
- CFG_WR, DATA_WR, START: IDLE -> SETUP on acceptance.
- Nibble order is LSB first: cmd_data[3:0], then [7:4], then [11:8], then [15:12].
- SETUP, 1 cycle: ui_in_drv = {0, 0, op, nibble}.
- STROBE, STROBE_CYCLES cycles: ui_in_drv = {0, 1, op, nibble}.
- After each STROBE phase, go to SETUP for the next nibble. After the 4th nibble:
  - ui_in_drv returns to 0 on the next cycle.
  - CFG_WR/DATA_WR go to IDLE.
  - START goes to WAIT_RSP.
- Write latency:
  - acceptance at edge N -> first SETUP drive visible after edge N+1.
  - back in IDLE after edge N+1+4*(1+STROBE_CYCLES).
  - default: 12 driven cycles, then cmd_ready=1.
- WAIT_RSP:
  - uio_out_smp[0] passes through a 2-flop synchronizer.
  - On the first cycle the synchronized bit is 1, capture uo_out_smp into rsp_data and go to RSP.
  - A valid already high on entry is accepted; no edge detect.
- RSP:
  - rsp_valid=1; rsp_data/rsp_err stay stable until rsp_ready.
  - On rsp_valid & rsp_ready, rsp_valid drops next cycle and state goes to IDLE.
- A new command cannot be accepted in the same cycle a response is consumed; cmd_ready rises the cycle after.
- cmd_valid is ignored outside IDLE. The command interface carries no backpressure errors.
- rst_n low in any state aborts the command; pins return to 0 on that edge.
- Nibble and phase counters are sized to hold STROBE_CYCLES and 4 nibbles exactly; no wrap beyond the terminal count.

Optional Feature:
- Macro: MINI_AIE_HOST_TIMEOUT_EN.
- Defined:
  - A counter clears on WAIT_RSP entry and increments each cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 without a synchronized valid, go to RSP with rsp_data=8'hFF and rsp_err=1.
  - If valid and timeout coincide in the same cycle, valid wins (rsp_err=0).
- Not defined:
  - No counter; WAIT_RSP waits indefinitely.
  - rsp_err is tied 0.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with cmd_valid=1 -> all outputs 0, cmd_ready=1, no acceptance.
- CFG_WR, data 16'hA5C3:
  - ui_in_drv sequence is 0x13 (1 cycle), 0x53 (2 cycles), 0x1C, 0x5C, 0x15, 0x55, 0x1A, 0x5A, then 0x00.
  - cmd_ready returns 1 exactly 13 cycles after acceptance.
- NOP back-to-back with DATA_WR 16'h0001:
  - NOP causes no pin change.
  - DATA_WR is accepted the next cycle and drives op bits 10: first drive 0x21, then 0x61.
- START 16'h0000, chip model raises uio_out[0] with uo_out=8'h3C 5 cycles after the last strobe:
  - rsp_valid rises 2 cycles after valid (synchronizer) plus 1 capture cycle.
  - rsp_data=0x3C, rsp_err=0.
  - Hold rsp_ready=0 for 4 cycles -> data stays stable; assert rsp_ready -> state returns to IDLE.
- Reset mid-STROBE of nibble 2 -> ui_in_drv=0 and busy=0 on the next edge; a subsequent CFG_WR runs normally from nibble 0.
- With MINI_AIE_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=16, START with no chip response -> rsp_valid with rsp_data=0xFF and rsp_err=1 after 16 WAIT_RSP cycles.
